// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encodings
// and the width of the read-return select register.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  localparam int RSEL_W = 2;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of consecutive cycles in which m1 asked for the port
// and was denied. The sat flag marks the point where m1 must preempt m0.
module mem_port_arbiter_starve_counter #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] count,
  output logic              sat
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  assign sat = (count == MAX_CNT);

  // Clear wins over increment; hold once the limit is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single data-memory port.
// m0 (CPU MEM stage) has fixed priority; m1 (loader) gets a starvation
// override after MAX_WAIT denied cycles; either master may lock the port
// across a burst. Registered read data is routed back to the issuing master
// one cycle after its read grant.
//
// Handshake: a master holds mx_req (with we/addr/wdata/lock) and the access
// is taken in the cycle mx_gnt is high; there is no backpressure on read
// return, mx_rvalid is a single-cycle pulse exactly one cycle after the
// granted read and mx_rdata is only meaningful while mx_rvalid is high.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  // master 0
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  // master 1
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  // observability
  output logic [1:0]        dbg_state,
  output logic [WAIT_W-1:0] dbg_wait_cnt
);

  arb_state_e        state;
  logic [RSEL_W-1:0] rsel_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starve_sat;
  logic              starve;

  mem_port_arbiter_starve_counter #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk  (clk),
    .rst  (reset),
    .inc  (m1_req & ~m1_gnt),
    .clr  (m1_gnt | ~m1_req),
    .count(wait_cnt),
    .sat  (starve_sat)
  );

  assign starve = m1_req & starve_sat;

  // Same-cycle grant: starvation override, then lock owner, then m0, then m1.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (starve) begin
      m1_gnt = 1'b1;
    end else if (state == ST_LOCK0 && m0_req) begin
      m0_gnt = 1'b1;
    end else if (state == ST_LOCK1 && m1_req) begin
      m1_gnt = 1'b1;
    end else if (m0_req) begin
      m0_gnt = 1'b1;
    end else if (m1_req) begin
      m1_gnt = 1'b1;
    end
  end

  // Port forwarding: the granted master drives the memory; m0 by default.
  always_comb begin
    mem_addr  = m1_gnt ? m1_addr  : m0_addr;
    mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
    mem_read  = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
    mem_write = (m0_gnt &  m0_we) | (m1_gnt &  m1_we);
  end

  // Lock FSM: ownership follows whoever was granted with lock asserted,
  // otherwise the port returns to IDLE (covers lock drop, owner idle and
  // a starvation grant breaking a LOCK0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (m0_gnt && m0_lock) begin
      state <= ST_LOCK0;
    end else if (m1_gnt && m1_lock) begin
      state <= ST_LOCK1;
    end else begin
      state <= ST_IDLE;
    end
  end

  // Remember which master's read is in flight so the data returns to it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsel_q <= '0;
    end else begin
      rsel_q <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
    end
  end

  assign m0_rvalid    = rsel_q[0];
  assign m1_rvalid    = rsel_q[1];
  assign m0_rdata     = mem_rdata;
  assign m1_rdata     = mem_rdata;
  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

endmodule
